// File: rtl/usb_pkg.sv
// Shared USB transmit-side definitions: PID bytes, arbiter states and
// requester indices used by the transmit arbiter and its picker.
package usb_pkg;

    // Token / data / handshake PID bytes as they appear on data_o
    localparam logic [7:0] PID_OUT   = 8'hE1;
    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_SOF   = 8'hA5;
    localparam logic [7:0] PID_SETUP = 8'h2D;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_STALL = 8'h1E;

    // Requester slots on the arbiter's 3-bit request vectors
    localparam int unsigned REQ_HS    = 0;
    localparam int unsigned REQ_CTRL  = 1;
    localparam int unsigned REQ_AUDIO = 2;
    localparam int unsigned NUM_REQ   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/usb_rr_pick.sv
// Combinational requester picker: the handshake generator always wins,
// control and audio share the link round-robin via a 1-bit pointer
// (ptr=0 favours control, ptr=1 favours audio).
module usb_rr_pick
    import usb_pkg::*;
(
    input  logic [2:0] req,
    input  logic       ptr,
    output logic [2:0] pick
);

    // One-hot winner: absolute priority first, then the pointer tie-break
    always_comb begin
        pick = '0;
        if (req[REQ_HS]) begin
            pick[REQ_HS] = 1'b1;
        end else if (req[REQ_CTRL] && req[REQ_AUDIO]) begin
            if (ptr) begin
                pick[REQ_AUDIO] = 1'b1;
            end else begin
                pick[REQ_CTRL] = 1'b1;
            end
        end else if (req[REQ_CTRL]) begin
            pick[REQ_CTRL] = 1'b1;
        end else if (req[REQ_AUDIO]) begin
            pick[REQ_AUDIO] = 1'b1;
        end
    end

endmodule

// File: rtl/usb_tx_arbiter.sv
// Shares one USB byte transmitter between the handshake generator, the
// control endpoint and the audio endpoint. A packet owns the link from
// its first byte to the byte marked last; packets are separated by an
// enforced idle gap, and a stalled or failing transmitter aborts the
// packet with a one-cycle error pulse.
module usb_tx_arbiter
    import usb_pkg::*;
#(
    parameter int unsigned GAP_CYCLES     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [2:0]  req_valid,
    input  logic [23:0] req_data,
    input  logic [2:0]  req_last,
    output logic [2:0]  req_ready,
    output logic [7:0]  data_o,
    output logic        data_o_start_stop,
    input  logic        data_o_strb,
    input  logic        data_o_fail,
    output logic [2:0]  grant,
    output logic        err_pulse
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] TMO_MAX  = CW'(TIMEOUT_CYCLES);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

    arb_state_t    state_q, state_d;
    logic [2:0]    grant_q, grant_d;
    logic          rr_q, rr_d;
    logic [CW-1:0] tmo_q, tmo_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [7:0]    hold_q, hold_d;
    logic          err_q, err_d;

    logic [2:0]    pick;
    logic          cur_valid;
    logic          cur_last;
    logic [7:0]    cur_byte;
    logic          pkt_end;

    usb_rr_pick u_pick (
        .req  (req_valid),
        .ptr  (rr_q),
        .pick (pick)
    );

    // Mux the granted requester's byte/valid/last (grant_q is one-hot or zero)
    always_comb begin
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        cur_byte  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                cur_valid = cur_valid | req_valid[i];
                cur_last  = cur_last  | req_last[i];
                cur_byte  = cur_byte  | req_data[8*i +: 8];
            end
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d           = state_q;
        grant_d           = grant_q;
        rr_d              = rr_q;
        tmo_d             = tmo_q;
        gap_d             = gap_q;
        hold_d            = hold_q;
        err_d             = 1'b0;
        pkt_end           = 1'b0;
        req_ready         = '0;
        data_o            = '0;
        data_o_start_stop = 1'b0;
        grant             = '0;

        case (state_q)
            ST_IDLE: begin
                tmo_d   = '0;
                gap_d   = '0;
                grant_d = '0;
                if (|req_valid) begin
                    grant_d = pick;
                    hold_d  = '0;
                    state_d = ST_SEND;
                end
            end

            ST_SEND: begin
                grant             = grant_q;
                data_o_start_stop = 1'b1;
                // During an underrun the last forwarded byte is replayed
                data_o            = cur_valid ? cur_byte : hold_q;
                if (cur_valid) begin
                    hold_d = cur_byte;
                end
                if (data_o_fail) begin
                    err_d   = 1'b1;
                    pkt_end = 1'b1;
                end else if (data_o_strb) begin
                    tmo_d = '0;
                    if (cur_valid) begin
                        req_ready = grant_q;
                        pkt_end   = cur_last;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    pkt_end = 1'b1;
                end else if (tmo_q != TMO_MAX) begin
                    tmo_d = tmo_q + CW'(1);
                end
                // Completion or abort hands the round-robin turn to the other endpoint
                if (pkt_end) begin
                    state_d = ST_GAP;
                    gap_d   = GAP_LOAD;
                    grant_d = '0;
                    if (grant_q[REQ_CTRL]) begin
                        rr_d = 1'b1;
                    end else if (grant_q[REQ_AUDIO]) begin
                        rr_d = 1'b0;
                    end
                end
            end

            ST_GAP: begin
                tmo_d   = '0;
                grant_d = '0;
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State, counters, pointer and error pulse registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            rr_q    <= 1'b0;
            tmo_q   <= '0;
            gap_q   <= '0;
            hold_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            tmo_q   <= tmo_d;
            gap_q   <= gap_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
        end
    end

    assign err_pulse = err_q;

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Directed bench for usb_tx_arbiter: single packet with gap timing,
// priority, round-robin, timeout, underrun hold, fail abort and
// mid-packet reset.
module tb_usb_tx_arbiter;
    import usb_pkg::*;

    logic        clk;
    logic        nrst;
    logic [2:0]  req_valid;
    logic [23:0] req_data;
    logic [2:0]  req_last;
    logic [2:0]  req_ready;
    logic [7:0]  data_o;
    logic        data_o_start_stop;
    logic        data_o_strb;
    logic        data_o_fail;
    logic [2:0]  grant;
    logic        err_pulse;

    int errors = 0;
    int checks = 0;

    usb_tx_arbiter #(
        .GAP_CYCLES     (8),
        .TIMEOUT_CYCLES (255)
    ) dut (
        .clk               (clk),
        .nrst              (nrst),
        .req_valid         (req_valid),
        .req_data          (req_data),
        .req_last          (req_last),
        .req_ready         (req_ready),
        .data_o            (data_o),
        .data_o_start_stop (data_o_start_stop),
        .data_o_strb       (data_o_strb),
        .data_o_fail       (data_o_fail),
        .grant             (grant),
        .err_pulse         (err_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int n, input logic v, input logic [7:0] d, input logic l);
        req_valid[n]       = v;
        req_data[8*n +: 8] = d;
        req_last[n]        = l;
    endtask

    // Count low start_stop cycles (bounded) until a packet starts
    task automatic wait_start(input int exp_n, input logic [2:0] exp_g,
                              input logic [7:0] exp_d, input string tag);
        int n = 0;
        while (data_o_start_stop !== 1'b1 && n < 40) begin
            n++;
            cyc();
        end
        chk({tag, "_lowcycles"}, n, exp_n);
        chk({tag, "_grant"}, {29'd0, grant}, {29'd0, exp_g});
        chk({tag, "_data"}, {24'd0, data_o}, {24'd0, exp_d});
    endtask

    // One byte from requester n: waits idle-strobe cycles, then a strobe
    task automatic xfer(input int n, input logic [7:0] d, input logic last,
                        input int waits, input string tag);
        logic [2:0] oh;
        oh = 3'b001 << n;
        set_req(n, 1'b1, d, last);
        for (int w = 0; w < waits; w++) begin
            #1;
            chk({tag, "_wait_data"}, {24'd0, data_o}, {24'd0, d});
            chk({tag, "_wait_ready"}, {29'd0, req_ready}, 32'd0);
            cyc();
        end
        data_o_strb = 1'b1;
        #1;
        chk({tag, "_ready"}, {29'd0, req_ready}, {29'd0, oh});
        chk({tag, "_ss"}, {31'd0, data_o_start_stop}, 32'd1);
        cyc();
        data_o_strb = 1'b0;
        if (last) set_req(n, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        int  n;
        logic seen;

        nrst        = 1'b0;
        req_valid   = '0;
        req_data    = '0;
        req_last    = '0;
        data_o_strb = 1'b0;
        data_o_fail = 1'b0;

        // Reset state
        #3;
        chk("rst_grant", {29'd0, grant}, 32'd0);
        chk("rst_ss", {31'd0, data_o_start_stop}, 32'd0);
        chk("rst_data", {24'd0, data_o}, 32'd0);
        chk("rst_ready", {29'd0, req_ready}, 32'd0);
        chk("rst_err", {31'd0, err_pulse}, 32'd0);
        cyc();
        cyc();
        nrst = 1'b1;
        cyc();

        // Single 3-byte control packet, strobe every 4 cycles
        set_req(1, 1'b1, 8'h2D, 1'b0);
        wait_start(1, 3'b010, 8'h2D, "single_start");
        xfer(1, 8'h2D, 1'b0, 3, "single_b0");
        xfer(1, 8'h00, 1'b0, 3, "single_b1");
        xfer(1, 8'h05, 1'b1, 3, "single_b2");
        #1;
        chk("single_end_ss", {31'd0, data_o_start_stop}, 32'd0);
        chk("single_end_grant", {29'd0, grant}, 32'd0);
        chk("single_end_data", {24'd0, data_o}, 32'd0);
        // 8 GAP cycles plus one IDLE cycle before the next start
        set_req(1, 1'b1, 8'hC3, 1'b1);
        wait_start(9, 3'b010, 8'hC3, "single_gap");
        xfer(1, 8'hC3, 1'b1, 0, "single_p2");

        // Reset restores the pointer to favour control
        nrst = 1'b0;
        #2;
        nrst = 1'b1;

        // Priority: all three valid
        set_req(0, 1'b1, PID_ACK, 1'b1);
        set_req(1, 1'b1, PID_DATA1, 1'b1);
        set_req(2, 1'b1, PID_DATA0, 1'b1);
        wait_start(1, 3'b001, PID_ACK, "prio_hs");
        xfer(0, PID_ACK, 1'b1, 1, "prio_hs");
        wait_start(9, 3'b010, PID_DATA1, "prio_ctrl");
        xfer(1, PID_DATA1, 1'b1, 1, "prio_ctrl");
        wait_start(9, 3'b100, PID_DATA0, "prio_audio");
        xfer(2, PID_DATA0, 1'b1, 1, "prio_audio");

        // Round-robin between continuously valid control and audio
        set_req(1, 1'b1, 8'h10, 1'b0);
        set_req(2, 1'b1, 8'h30, 1'b0);
        for (int k = 0; k < 4; k++) begin
            int g;
            logic [7:0] b0;
            g  = (k % 2 == 0) ? 1 : 2;
            b0 = (g == 1) ? 8'h10 : 8'h30;
            wait_start(9, 3'b001 << g, b0, "rr");
            xfer(g, b0, 1'b0, 0, "rr_b0");
            xfer(g, b0 + 8'h01, 1'b1, 0, "rr_b1");
            set_req(g, 1'b1, b0, 1'b0);
        end

        // Timeout: control granted, transmitter never strobes
        set_req(2, 1'b0, 8'h00, 1'b0);
        wait_start(9, 3'b010, 8'h10, "tmo_start");
        n    = 0;
        seen = 1'b0;
        while (data_o_start_stop === 1'b1 && n < 400) begin
            if (req_ready !== 3'b000) seen = 1'b1;
            n++;
            cyc();
        end
        chk("tmo_cycles", n, 255);
        chk("tmo_no_ready", {31'd0, seen}, 32'd0);
        chk("tmo_err", {31'd0, err_pulse}, 32'd1);
        cyc();
        chk("tmo_err_once", {31'd0, err_pulse}, 32'd0);
        // Pointer moved to audio after the control abort
        set_req(2, 1'b1, 8'h01, 1'b0);
        wait_start(8, 3'b100, 8'h01, "tmo_ptr");

        // Audio: byte 1, an underrun with a stray strobe, then fail+strobe on byte 2
        xfer(2, 8'h01, 1'b0, 1, "fail_b1");
        set_req(2, 1'b0, 8'hEE, 1'b0);
        data_o_strb = 1'b1;
        #1;
        chk("underrun_data", {24'd0, data_o}, 32'h01);
        chk("underrun_ready", {29'd0, req_ready}, 32'd0);
        chk("underrun_ss", {31'd0, data_o_start_stop}, 32'd1);
        cyc();
        set_req(2, 1'b1, 8'h02, 1'b0);
        data_o_strb = 1'b1;
        data_o_fail = 1'b1;
        #1;
        chk("fail_ready", {29'd0, req_ready}, 32'd0);
        cyc();
        data_o_strb = 1'b0;
        data_o_fail = 1'b0;
        #1;
        chk("fail_ss", {31'd0, data_o_start_stop}, 32'd0);
        chk("fail_err", {31'd0, err_pulse}, 32'd1);
        // A fail pulse outside SEND is ignored
        cyc();
        data_o_fail = 1'b1;
        cyc();
        data_o_fail = 1'b0;
        #1;
        chk("fail_idle_ignored", {31'd0, err_pulse}, 32'd0);
        set_req(1, 1'b1, 8'h10, 1'b1);
        set_req(2, 1'b1, 8'h22, 1'b1);
        wait_start(7, 3'b010, 8'h10, "fail_ptr");
        xfer(1, 8'h10, 1'b1, 0, "fail_ctrl");

        // Mid-packet reset during an audio packet
        set_req(1, 1'b1, PID_NAK, 1'b1);
        set_req(2, 1'b1, 8'h11, 1'b0);
        wait_start(9, 3'b100, 8'h11, "mrst_start");
        data_o_strb = 1'b1;
        #1;
        nrst = 1'b0;
        #1;
        chk("mrst_ss", {31'd0, data_o_start_stop}, 32'd0);
        chk("mrst_grant", {29'd0, grant}, 32'd0);
        chk("mrst_data", {24'd0, data_o}, 32'd0);
        chk("mrst_ready", {29'd0, req_ready}, 32'd0);
        chk("mrst_err", {31'd0, err_pulse}, 32'd0);
        data_o_strb = 1'b0;
        cyc();
        #1;
        nrst = 1'b1;
        wait_start(1, 3'b010, PID_NAK, "mrst_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/usb_tx_arbiter.md
USB_TX_ARBITER -- requirements
Module: usb_tx_arbiter

Interface
REQ-001 Parameter GAP_CYCLES, default 8, minimum idle clk cycles between packets.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, maximum clk cycles waiting for a transmitter byte strobe.
REQ-003 clk  in  1  system clock, all logic on rising edge.
REQ-004 nrst  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  3  per-requester byte valid: bit0 handshake generator, bit1 control endpoint, bit2 audio endpoint.
REQ-006 req_data  in  24  per-requester byte, requester n on bits [8n+7:8n], first byte is the PID.
REQ-007 req_last  in  3  marks the requester's current byte as the final byte of its packet.
REQ-008 req_ready  out  3  one-hot byte-accept pulse to the granted requester.
REQ-009 data_o  out  8  byte to the shared transmitter.
REQ-010 data_o_start_stop  out  1  high for the whole packet and low otherwise.
REQ-011 data_o_strb  in  1  transmitter has consumed data_o.
REQ-012 data_o_fail  in  1  transmitter abort.
REQ-013 grant  out  3  one-hot current owner, zero when none.
REQ-014 err_pulse  out  1  one-cycle pulse on a timeout or a transmitter fail.

Function
REQ-015 States: IDLE, SEND, GAP.
REQ-016 IDLE: grant is evaluated every cycle when any req_valid is high; bit0 has absolute priority; bits 1 and 2 are arbitrated round-robin through a 1-bit pointer that is initialised to favour bit1.
REQ-017 IDLE to SEND: on the cycle after the winner is latched, grant becomes one-hot, data_o carries that requester's current byte, and data_o_start_stop rises; latency from req_valid to start is 1 cycle.
REQ-018 SEND forwarding: data_o and data_o_start_stop follow the granted requester combinationally; in SEND, req_ready[g] = data_o_strb AND req_valid[g].
REQ-019 SEND with req_valid[g] low: data_o_start_stop stays high and data_o stays at its last value; a data_o_strb in that cycle is ignored (underrun hold).
REQ-020 SEND end: a byte accepted with req_last high takes the block to GAP; data_o_start_stop falls on the next cycle.
REQ-021 Timeout: the counter resets on every data_o_strb; on reaching TIMEOUT_CYCLES the block pulses err_pulse and goes to GAP; the requester is not given req_ready.
REQ-022 data_o_fail in SEND: err_pulse is pulsed and the block goes to GAP immediately; data_o_fail has priority over a simultaneous data_o_strb; data_o_fail outside SEND is ignored.
REQ-023 GAP: grant=0, data_o=0, data_o_start_stop=0; the gap counter loads GAP_CYCLES-1 on entry and the block returns to IDLE when the counter reaches 0.
REQ-024 Round-robin pointer: it toggles away from bit1 or bit2 only when that requester completes or aborts a packet; bit0 packets do not move it.
REQ-025 A requester that drops req_valid before winning loses nothing; arbitration is re-run every IDLE cycle.
REQ-026 Pre-emption: a new higher-priority request never pre-empts a packet in progress.
REQ-027 Counter width: clog2(TIMEOUT_CYCLES+1) bits, saturating, with no wrap.

Reset
REQ-028 Reset values: nrst low forces IDLE, grant=0, data_o=0, data_o_start_stop=0, req_ready=0, err_pulse=0, both counters 0, and the round-robin pointer favouring bit1.
REQ-029 Reset mid-packet: it drops data_o_start_stop asynchronously with no GAP; the first post-reset grant is no earlier than 1 cycle after nrst rises.

Structure
REQ-030 Shared package (usb_pkg): PID constants (ACK, NAK, STALL, DATA0/1, ...), the state enumeration, and requester index constants (REQ_HS=0, REQ_CTRL=1, REQ_AUDIO=2).
REQ-031 Sub-module: one sub-module, usb_rr_pick, which is a combinational priority/round-robin picker of 3 bits in and one-hot out; the rest is a single FSM.

Verification
REQ-032 Single request: bit1 sends the 3-byte packet 0x2D,0x00,0x05 with data_o_strb every 4 cycles -> data_o_start_stop is high for the whole packet, 3 req_ready pulses, start_stop falls 1 cycle after the last strb, 8 GAP cycles follow, then IDLE.
REQ-033 Priority: bits 0,1,2 all valid in IDLE -> grant=001 sends 0xD2, then grant=010, then grant=100, each separated by 8 idle cycles.
REQ-034 Round-robin: bits 1 and 2 continuously valid with 2-byte packets -> grants alternate 010,100,010,100.
REQ-035 Timeout: data_o_strb is held low for 255 cycles in SEND -> err_pulse for one cycle, no req_ready, GAP entered, and the pointer advances.
REQ-036 Fail: data_o_fail and data_o_strb are asserted together on byte 2 -> err_pulse, no req_ready for byte 2, data_o_start_stop low the next cycle.
REQ-037 Reset mid-packet: nrst is pulsed during byte 1 of a bit2 packet -> all outputs 0 immediately, and bit1 wins first after release.
